// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: in-order instruction fetch queue with redirect squash and stale-response discard
//   clk, reset          : clock, asynchronous active-high reset
//   fetch_en            : permits new memory requests
//   redirect_valid/_pc  : branch/jump redirect (highest priority)
//   imem_req_*          : fetch request handshake, word-aligned address
//   imem_rsp_*          : in-order responses, one per accepted request
//   out_*               : head instruction to decode, out_ready stalls
module fetch_queue_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int PW = AW + 1;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q [FQ_DEPTH];
  logic [XLEN-1:0] instr_q [FQ_DEPTH];
  // Pointers carry one extra wrap bit so differences give occupancy directly;
  // an entry is filled exactly when it lies between the read and fill pointers.
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] discard_q, discard_d;
  logic [PW-1:0] alloc_cnt, unfilled_cnt;
  logic req_fire, fill, pop, head_filled;

  assign alloc_cnt      = alloc_ptr_q - rd_ptr_q;
  assign unfilled_cnt   = alloc_ptr_q - fill_ptr_q;
  // Outstanding stale responses still occupy credits until they drain.
  assign imem_req_valid = !reset && fetch_en && !redirect_valid && (alloc_cnt + discard_q < PW'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && !redirect_valid && discard_q == '0;
  assign head_filled    = fill_ptr_q != rd_ptr_q;
  assign out_valid      = head_filled && !redirect_valid;
  assign pop            = out_valid && out_ready;
  assign out_pc         = out_valid ? pc_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_instr      = out_valid ? instr_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_pc_plus4   = out_valid ? out_pc + XLEN'(4) : '0;

  always_comb begin
    fetch_pc_d  = redirect_valid ? (redirect_pc & ~XLEN'(3)) : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    alloc_ptr_d = redirect_valid ? '0 : alloc_ptr_q + PW'(req_fire);
    fill_ptr_d  = redirect_valid ? '0 : fill_ptr_q + PW'(fill);
    rd_ptr_d    = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    // A response arriving with the redirect consumes one of the squashed requests.
    discard_d   = redirect_valid ? discard_q + unfilled_cnt - PW'(imem_rsp_valid)
                                 : discard_q - PW'(imem_rsp_valid && discard_q != '0);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc_q  <= RESET_PC & ~XLEN'(3);
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      discard_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      discard_q   <= discard_d;
    end

  always_ff @(posedge clk) begin
    if (req_fire) pc_q[alloc_ptr_q[AW-1:0]] <= fetch_pc_q;
    if (fill) instr_q[fill_ptr_q[AW-1:0]] <= imem_rsp_data;
  end

  rsp_outstanding_a: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (unfilled_cnt != '0 || discard_q != '0));
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter XLEN, default 32: address/instruction width.
REQ-002 Parameter RESET_PC, default 0: fetch PC after reset.
REQ-003 Parameter FQ_DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 Port clk  in  1: clock; all state updates on rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port fetch_en  in  1: permits new memory requests when high.
REQ-007 Port redirect_valid  in  1: branch/jump redirect strobe.
REQ-008 Port redirect_pc  in  XLEN: redirect target.
REQ-009 Port imem_req_valid  out  1: fetch request valid.
REQ-010 Port imem_req_ready  in  1: memory accepts request.
REQ-011 Port imem_req_addr  out  XLEN: fetch address, bits [1:0] always 0.
REQ-012 Port imem_rsp_valid  in  1: response valid; responses return in request order, one per accepted request, latency >= 1 cycle.
REQ-013 Port imem_rsp_data  in  XLEN: fetched instruction.
REQ-014 Port out_valid  out  1: decode-side instruction valid.
REQ-015 Port out_ready  in  1: decode accepts (low = stall).
REQ-016 Port out_pc, out_pc_plus4, out_instr  out  XLEN each: head entry PC, PC+4, instruction.

Function
REQ-017 Internal: fetch_pc register; circular buffer of FQ_DEPTH entries {pc, instr, filled}; alloc, fill, read pointers; discard_cnt; count widths $clog2(FQ_DEPTH)+1.
REQ-018 Entry allocated (pc = fetch_pc, filled = 0) on imem_req_valid && imem_req_ready; fetch_pc then advances by 4, wrapping modulo 2^XLEN.
REQ-019 imem_req_valid = fetch_en && !redirect_valid && (allocated entries + discard_cnt < FQ_DEPTH); imem_req_addr = fetch_pc.
REQ-020 imem_req_valid/addr, once asserted, stay stable until accepted unless a redirect occurs.
REQ-021 Response with discard_cnt == 0: writes imem_rsp_data into the oldest unfilled entry, sets filled, advances fill pointer.
REQ-022 Response with discard_cnt > 0: data dropped, discard_cnt decrements, no entry changes.
REQ-023 out_valid = head entry allocated && filled && !redirect_valid; out_pc_plus4 = out_pc + 4 (modulo 2^XLEN).
REQ-024 Pop on out_valid && out_ready; head freed, read pointer advances.
REQ-025 Alloc, fill and pop allowed in the same cycle, including a full queue popping while allocating.
REQ-026 Response data never bypasses to out_* in its arrival cycle; minimum response-to-out_valid latency is 1 cycle.
REQ-027 Redirect (highest priority): all entries invalidated; pointers equalised; fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; no request issued or pop performed that cycle.
REQ-028 On redirect, discard_cnt <= discard_cnt + unfilled allocated entries - (imem_rsp_valid ? 1 : 0).
REQ-029 Back-to-back redirects: last one wins; discard_cnt accumulates per REQ-028.
REQ-030 Requests after a redirect are issued as soon as credits (REQ-019) permit, including while discard_cnt > 0.
REQ-031 fetch_en low stops new requests only; outstanding responses still fill or discard, and queued entries still drain.
REQ-032 A response received with no outstanding request is a protocol violation; behaviour undefined, asserted in simulation.

Reset
REQ-033 Reset is asynchronous: fetch_pc = RESET_PC, all pointers, counts and discard_cnt = 0, all filled = 0.
REQ-034 During and immediately after reset: imem_req_valid = 0 while reset is high, out_valid = 0, out_* data = 0.
REQ-035 Reset asserted mid-operation abandons all state; responses arriving after reset to requests issued before it are a protocol violation, and the bench drains memory with the DUT.

Verification
REQ-036 Reset, fetch_en = 1, memory 1-cycle latency, out_ready = 1 -> addresses 0x0, 0x4, 0x8...; out_pc sequence 0x0, 0x4...; out_pc_plus4 = out_pc + 4; throughput 1 per cycle.
REQ-037 Hold out_ready = 0, FQ_DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0; after out_ready = 1, one new request per pop.
REQ-038 Memory latency 3, 2 requests outstanding, redirect to 0x103 -> next address 0x100; 2 stale responses dropped; first out_pc = 0x100 with the 0x100 data.
REQ-039 Redirect in the same cycle as imem_rsp_valid and out_valid/out_ready -> no pop, arriving response dropped, discard_cnt = unfilled - 1.
REQ-040 fetch_pc = 0xFFFFFFFC -> next address 0x00000000; out_pc_plus4 = 0x00000000.
REQ-041 Assert reset while 3 entries are queued and imem_req_valid is high -> out_valid and imem_req_valid drop immediately; first post-reset address is RESET_PC.
